// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM state encoding
// and the request-legality helper.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_DATA  = 3'd2,
    ST_WRITE = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

  // Stores only exist for B/H/W; loads additionally allow BU/HU.
  function automatic logic f3_illegal(input logic i_we, input logic [2:0] i_f3);
    return (i_f3 == 3'b011) || (i_f3[2] && i_f3[1]) ||
           (i_we && (i_f3[2] || (i_f3[1] && i_f3[0])));
  endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Combinational lane steering: load extraction/extension, sub-word store merge
// and alignment check for a little-endian 32-bit word.
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load_data,
  output logic [31:0] o_store_word,
  output logic        o_misalign
);

  logic [4:0]  w_bsh;
  logic [4:0]  w_hsh;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_bsh  = {i_addr_lo, 3'b000};
  assign w_hsh  = {i_addr_lo[1], 4'b0000};
  assign w_byte = 8'(i_word >> w_bsh);
  assign w_half = 16'(i_word >> w_hsh);

  always_comb begin
    o_load_data  = i_word;
    o_store_word = i_word;
    case (i_funct3)
      F3_B: begin
        o_load_data  = {{24{w_byte[7]}}, w_byte};
        o_store_word = (i_word & ~(32'h0000_00FF << w_bsh)) | ({24'd0, i_wdata[7:0]} << w_bsh);
      end
      F3_BU: o_load_data = {24'd0, w_byte};
      F3_H: begin
        o_load_data  = {{16{w_half[15]}}, w_half};
        o_store_word = (i_word & ~(32'h0000_FFFF << w_hsh)) | ({16'd0, i_wdata[15:0]} << w_hsh);
      end
      F3_HU: o_load_data = {16'd0, w_half};
      F3_W:  o_store_word = i_wdata;
      default: ;
    endcase
  end

  assign o_misalign = ((i_funct3[1:0] == 2'b01) && i_addr_lo[0]) ||
                      ((i_funct3[1:0] == 2'b10) && (i_addr_lo != 2'b00));

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns RISC-V load/store requests into word-aligned accesses
// on a synchronous-read data memory, using read-modify-write for SB/SH.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [2:0]        i_req_funct3,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [31:0]       i_req_wdata,
  output logic              o_rsp_valid,
  output logic [31:0]       o_rsp_rdata,
  output logic              o_rsp_err,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  input  logic [31:0]       i_mem_rdata
);

  state_t            r_state, w_next;
  logic              r_we;
  logic [2:0]        r_funct3;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_word;
  logic              r_err;

  logic              w_idle;
  logic              w_accept;
  logic [1:0]        w_lane_addr;
  logic [2:0]        w_lane_f3;
  logic [31:0]       w_load_data;
  logic [31:0]       w_store_word;
  logic              w_misalign;
  logic              w_req_err;

  assign w_idle   = (r_state == ST_IDLE);
  assign w_accept = i_req_valid & w_idle;

  // In IDLE the lane checks the incoming request; afterwards it works on the latched one.
  assign w_lane_addr = w_idle ? i_req_addr[1:0] : r_addr[1:0];
  assign w_lane_f3   = w_idle ? i_req_funct3    : r_funct3;
  assign w_req_err   = w_misalign | f3_illegal(i_req_we, i_req_funct3);

  lsu_byte_lane u_lane (
    .i_word       (r_word),
    .i_addr_lo    (w_lane_addr),
    .i_funct3     (w_lane_f3),
    .i_wdata      (r_wdata),
    .o_load_data  (w_load_data),
    .o_store_word (w_store_word),
    .o_misalign   (w_misalign)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_req_err)                              w_next = ST_RESP;
          else if (i_req_we && i_req_funct3 == F3_W)  w_next = ST_WRITE;
          else                                        w_next = ST_ADDR;
        end
      end
      ST_ADDR:  w_next = ST_DATA;
      ST_DATA:  w_next = r_we ? ST_WRITE : ST_RESP;
      ST_WRITE: w_next = ST_RESP;
      ST_RESP:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_we     <= 1'b0;
      r_funct3 <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_word   <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_we     <= i_req_we;
        r_funct3 <= i_req_funct3;
        r_addr   <= i_req_addr;
        r_wdata  <= i_req_wdata;
        r_err    <= w_req_err;
      end
      if (r_state == ST_DATA) r_word <= i_mem_rdata;
    end
  end

  // All outputs decode from the state register, so o_mem_we cannot glitch.
  assign o_req_ready = w_idle;
  assign o_rsp_valid = (r_state == ST_RESP);
  assign o_rsp_err   = (r_state == ST_RESP) & r_err;
  assign o_rsp_rdata = ((r_state == ST_RESP) && !r_we && !r_err) ? w_load_data : 32'd0;
  assign o_mem_we    = (r_state == ST_WRITE);
  assign o_mem_addr  = {r_addr[ADDR_W-1:2], 2'b00};
  assign o_mem_wdata = (r_state == ST_WRITE) ? w_store_word : 32'd0;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, reset/back-to-back sequences
// and randomized requests checked against a byte-level reference model.
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_f3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  load_store_unit #(.ADDR_W(32)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_we     (req_we),
    .i_req_funct3 (req_f3),
    .i_req_addr   (req_addr),
    .i_req_wdata  (req_wdata),
    .o_rsp_valid  (rsp_valid),
    .o_rsp_rdata  (rsp_rdata),
    .o_rsp_err    (rsp_err),
    .o_mem_we     (mem_we),
    .o_mem_addr   (mem_addr),
    .o_mem_wdata  (mem_wdata),
    .i_mem_rdata  (mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [31:0] mem     [0:63];
  logic [31:0] ref_mem [0:63];

  // Synchronous-read memory, preloaded with 0xDEADBEEF at byte address 0x8.
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
    mem[2] = 32'hDEAD_BEEF;
    mem_rdata = 32'd0;
    forever begin
      @(posedge clk);
      mem_rdata <= mem[mem_addr[7:2]];
      if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
    end
  end

  int          we_cnt;
  logic [31:0] last_waddr;
  logic [31:0] last_wdata;
  logic [32:0] rsp_q[$];

  initial begin
    we_cnt     = 0;
    last_waddr = 32'd0;
    last_wdata = 32'd0;
    forever begin
      @(posedge clk);
      if (mem_we) begin
        we_cnt++;
        last_waddr = mem_addr;
        last_wdata = mem_wdata;
      end
      if (rsp_valid) rsp_q.push_back({rsp_err, rsp_rdata});
    end
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Reference model: works byte by byte on ref_mem from the architectural rules.
  task automatic model_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, output logic [31:0] rd, output logic er,
                          output int lat);
    int f, width, off, idx;
    logic [31:0] word, val;
    f     = int'(f3);
    width = (f % 4 == 0) ? 1 : (f % 4 == 1) ? 2 : 4;
    off   = int'(addr % 4);
    idx   = int'((addr / 4) % 64);
    er    = (f == 3) || (f == 6) || (f == 7) || (we && f >= 3) || (addr % width != 0);
    rd    = 32'd0;
    word  = ref_mem[idx];
    if (er) begin
      lat = 1;
    end else if (we) begin
      for (int b = 0; b < width; b++)
        word = (word & ~(32'hFF << (8 * (off + b)))) | (((wd >> (8 * b)) & 32'hFF) << (8 * (off + b)));
      ref_mem[idx] = word;
      lat = (width == 4) ? 2 : 4;
    end else begin
      val = 32'd0;
      for (int b = 0; b < width; b++)
        val = val | (((word >> (8 * (off + b))) & 32'hFF) << (8 * b));
      if (f < 4 && width < 4 && val[8 * width - 1]) val = val | (32'hFFFF_FFFF << (8 * width));
      rd  = val;
      lat = 3;
    end
  endtask

  // Issue one request from a negedge; returns response, latency in cycles and write count.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er,
                        output int lat, output int wes);
    int w0, n;
    w0        = we_cnt;
    req_valid = 1'b1;
    req_we    = we;
    req_f3    = f3;
    req_addr  = addr;
    req_wdata = wd;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    rd = rsp_rdata;
    er = rsp_err;
    @(negedge clk);
    wes = we_cnt - w0;
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    logic [31:0] exp_wword;
  } vec_t;

  vec_t vecs[14];

  initial begin
    logic [31:0] rd, m_rd, b2b_rd[3];
    logic        er, m_er, b2b_er[3];
    int          lat, m_lat, wes, w0, r0, n;
    logic        b_we[3];
    logic [2:0]  b_f3[3];
    logic [31:0] b_addr[3], b_wd[3];

    for (int i = 0; i < 64; i++) ref_mem[i] = 32'd0;
    ref_mem[2] = 32'hDEAD_BEEF;

    vecs[0]  = '{1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 32'h0,         1'b0, 2, 32'hDEAD_BEEF};
    vecs[1]  = '{1'b0, 3'b000, 32'h09, 32'h0,         32'hFFFF_FFBE, 1'b0, 3, 32'h0};
    vecs[2]  = '{1'b0, 3'b100, 32'h09, 32'h0,         32'h0000_00BE, 1'b0, 3, 32'h0};
    vecs[3]  = '{1'b0, 3'b001, 32'h0A, 32'h0,         32'hFFFF_DEAD, 1'b0, 3, 32'h0};
    vecs[4]  = '{1'b0, 3'b101, 32'h0A, 32'h0,         32'h0000_DEAD, 1'b0, 3, 32'h0};
    vecs[5]  = '{1'b0, 3'b010, 32'h08, 32'h0,         32'hDEAD_BEEF, 1'b0, 3, 32'h0};
    vecs[6]  = '{1'b1, 3'b000, 32'h0B, 32'h12,        32'h0,         1'b0, 4, 32'h12AD_BEEF};
    vecs[7]  = '{1'b0, 3'b010, 32'h08, 32'h0,         32'h12AD_BEEF, 1'b0, 3, 32'h0};
    vecs[8]  = '{1'b1, 3'b001, 32'h08, 32'hCAFE,      32'h0,         1'b0, 4, 32'h12AD_CAFE};
    vecs[9]  = '{1'b0, 3'b010, 32'h08, 32'h0,         32'h12AD_CAFE, 1'b0, 3, 32'h0};
    vecs[10] = '{1'b0, 3'b010, 32'h06, 32'h0,         32'h0,         1'b1, 1, 32'h0};
    vecs[11] = '{1'b1, 3'b001, 32'h09, 32'h5555,      32'h0,         1'b1, 1, 32'h0};
    vecs[12] = '{1'b0, 3'b111, 32'h00, 32'h0,         32'h0,         1'b1, 1, 32'h0};
    vecs[13] = '{1'b0, 3'b010, 32'h10, 32'h0,         32'hDEAD_BEEF, 1'b0, 3, 32'h0};

    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_f3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0;
    #1;
    chk("reset ready", 32'(req_ready), 32'd1);
    chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset rsp_rdata", rsp_rdata, 32'd0);
    chk("reset rsp_err", 32'(rsp_err), 32'd0);
    chk("reset mem_we", 32'(mem_we), 32'd0);
    chk("reset mem_addr", mem_addr, 32'd0);
    chk("reset mem_wdata", mem_wdata, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vector table.
    for (int i = 0; i < 14; i++) begin
      model_op(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, m_rd, m_er, m_lat);
      do_req(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, rd, er, lat, wes);
      chk($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("vec%0d err", i), 32'(er), 32'(vecs[i].exp_err));
      chk($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      chk($sformatf("vec%0d write count", i), 32'(wes),
          (vecs[i].we && !vecs[i].exp_err) ? 32'd1 : 32'd0);
      if (vecs[i].we && !vecs[i].exp_err) begin
        chk($sformatf("vec%0d write addr", i), last_waddr, vecs[i].addr & ~32'h3);
        chk($sformatf("vec%0d write data", i), last_wdata, vecs[i].exp_wword);
      end
    end

    // Reset while an SB sits in DATA: no write, no response, memory untouched.
    req_valid = 1'b1; req_we = 1'b1; req_f3 = 3'b000; req_addr = 32'h8; req_wdata = 32'h55;
    w0 = we_cnt;
    r0 = rsp_q.size();
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset mem_we", 32'(mem_we), 32'd0);
    chk("midreset ready", 32'(req_ready), 32'd1);
    chk("midreset rsp_valid", 32'(rsp_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("midreset no write", 32'(we_cnt - w0), 32'd0);
    chk("midreset no response", 32'(rsp_q.size() - r0), 32'd0);
    chk("midreset ready after", 32'(req_ready), 32'd1);
    chk("midreset word intact", mem[2], ref_mem[2]);
    model_op(1'b0, 3'b010, 32'h8, 32'd0, m_rd, m_er, m_lat);
    do_req(1'b0, 3'b010, 32'h8, 32'd0, rd, er, lat, wes);
    chk("midreset readback", rd, m_rd);

    // Back-to-back with valid held high: LW, SW, LB.
    b_we[0] = 1'b0; b_f3[0] = 3'b010; b_addr[0] = 32'h08; b_wd[0] = 32'd0;
    b_we[1] = 1'b1; b_f3[1] = 3'b010; b_addr[1] = 32'h20; b_wd[1] = 32'hA5A5_5A5A;
    b_we[2] = 1'b0; b_f3[2] = 3'b000; b_addr[2] = 32'h09; b_wd[2] = 32'd0;
    for (int k = 0; k < 3; k++) model_op(b_we[k], b_f3[k], b_addr[k], b_wd[k], b2b_rd[k], b2b_er[k], m_lat);
    rsp_q.delete();
    req_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      req_we = b_we[k]; req_f3 = b_f3[k]; req_addr = b_addr[k]; req_wdata = b_wd[k];
      n = 0;
      while (!req_ready && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk($sformatf("b2b%0d accepted in time", k), 32'(n < 20), 32'd1);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("b2b%0d ready low while busy", k), 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    repeat (8) @(negedge clk);
    chk("b2b response count", 32'(rsp_q.size()), 32'd3);
    for (int k = 0; k < 3; k++) begin
      if (k < rsp_q.size()) chk($sformatf("b2b%0d response", k), rsp_q[k], {b2b_er[k], b2b_rd[k]});
      else chk($sformatf("b2b%0d response missing", k), 32'd0, 32'd1);
    end
    chk("b2b stored word", mem[8], ref_mem[8]);

    // Randomized requests against the reference model.
    for (int i = 0; i < 60; i++) begin
      logic        r_we;
      logic [2:0]  r_f3;
      logic [31:0] r_addr, r_wd;
      int          idx;
      r_we   = 1'($urandom_range(0, 1));
      r_f3   = 3'($urandom_range(0, 7));
      r_addr = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 2) == 0) r_addr = r_addr & ~32'h3;
      r_wd   = $urandom;
      idx    = int'(r_addr[7:2]);
      model_op(r_we, r_f3, r_addr, r_wd, m_rd, m_er, m_lat);
      do_req(r_we, r_f3, r_addr, r_wd, rd, er, lat, wes);
      chk($sformatf("rnd%0d rdata", i), rd, m_rd);
      chk($sformatf("rnd%0d err", i), 32'(er), 32'(m_er));
      chk($sformatf("rnd%0d latency", i), 32'(lat), 32'(m_lat));
      chk($sformatf("rnd%0d write count", i), 32'(wes), (r_we && !m_er) ? 32'd1 : 32'd0);
      chk($sformatf("rnd%0d memory word", i), mem[idx], ref_mem[idx]);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
